serial_demux_ctrl: RTL and testbench

//  Parametrised serial-frame demultiplexer: receives frames on a 1-bit line, decodes a

---
 rtl/serial_demux_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_serial_demux_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_demux_ctrl.sv
`timescale 1ns/1ps
// serial_demux_ctrl
// Serial-frame demultiplexer. Each frame is a start bit (0), an ADDR_W-bit channel
// address and an LEN_W-bit payload length, all MSB-first, then `length` payload bits.
// Payload bits are routed to ser_out[chan]. A length above MAX_LEN puts the block in an
// error state that clears only after RESYNC consecutive idle (1) bits on the line.
// All state advances only on clock edges with clk_en=1.
//
// Ports:
//   clk           system clock
//   rst           asynchronous reset, active-low
//   clk_en        bit strobe
//   ser_in        serial line (idle=1)
//   ser_out       ser_out[chan] follows ser_in while in DATA, all other bits 0
//   ser_out_valid high while in DATA
//   done          high for the single step following a completed frame
//   err           high while in the length-overflow error state
//   chan          last decoded channel address
//   ssd_out       seven-segment hex digit of chan, {g,f,e,d,c,b,a}, one clock behind chan
module serial_demux_ctrl #(
    parameter int unsigned ADDR_W         = 2,
    parameter int unsigned LEN_W          = 4,
    parameter int unsigned MAX_LEN        = 2**LEN_W - 1,
    parameter int unsigned RESYNC         = 4,
    parameter bit          SSD_ACTIVE_LOW = 1'b1,
    localparam int unsigned NCH           = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              ser_in,
    output logic [NCH-1:0]    ser_out,
    output logic              ser_out_valid,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] chan,
    output logic [6:0]        ssd_out
);

    // One shared counter: field bit index, remaining payload, or idle-run length.
    localparam int unsigned M1     = (MAX_LEN > RESYNC) ? MAX_LEN : RESYNC;
    localparam int unsigned M2     = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
    localparam int unsigned CntMax = (M1 > M2) ? M1 : M2;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [2:0] {StIdle, StAddr, StLen, StData, StDone, StErr} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_shift;
    logic [LEN_W-1:0]  len_q, len_d, len_shift;
    logic [ADDR_W-1:0] chan_q, chan_d;
    logic              valid_q, done_q, err_q;
    logic [6:0]        ssd_q;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s ^ {7{SSD_ACTIVE_LOW}};
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        len_d      = len_q;
        chan_d     = chan_q;
        // Shift-in views with the current bit appended; truncation drops the oldest bit.
        addr_shift = ADDR_W'({addr_q, ser_in});
        len_shift  = LEN_W'({len_q, ser_in});
        if (clk_en) begin
            case (state_q)
                StIdle: begin
                    if (!ser_in) begin
                        state_d = StAddr;
                        cnt_d   = '0;
                    end
                end
                StAddr: begin
                    addr_d = addr_shift;
                    if (cnt_q == CntW'(ADDR_W - 1)) begin
                        chan_d  = addr_shift;
                        cnt_d   = '0;
                        state_d = StLen;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StLen: begin
                    len_d = len_shift;
                    if (cnt_q == CntW'(LEN_W - 1)) begin
                        cnt_d = '0;
                        if (len_shift == '0) begin
                            state_d = StDone;
                        end else if (32'(len_shift) > MAX_LEN) begin
                            state_d = StErr;
                        end else begin
                            state_d = StData;
                            cnt_d   = CntW'(len_shift);
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StData: begin
                    if (cnt_q == CntW'(1)) begin
                        state_d = StDone;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                StDone: begin
                    // A start bit here is deliberately ignored.
                    state_d = StIdle;
                end
                StErr: begin
                    if (ser_in) begin
                        if (cnt_q == CntW'(RESYNC - 1)) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ssd_q   <= hex7(4'h0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            chan_q  <= chan_d;
            // Flags registered from the next state so they line up with state_q.
            valid_q <= (state_d == StData);
            done_q  <= (state_d == StDone);
            err_q   <= (state_d == StErr);
            ssd_q   <= hex7(4'(chan_q));
        end
    end

    always_comb begin
        ser_out = '0;
        if (valid_q) begin
            ser_out[chan_q] = ser_in;
        end
    end

    assign ser_out_valid = valid_q;
    assign done          = done_q;
    assign err           = err_q;
    assign chan          = chan_q;
    assign ssd_out       = ssd_q;

endmodule

// File: tb/tb_serial_demux_ctrl.sv
`timescale 1ns/1ps
// Directed bench for serial_demux_ctrl (ADDR_W=2, LEN_W=4, MAX_LEN=10, RESYNC=4).
module tb_serial_demux_ctrl;

    localparam int ADDR_W  = 2;
    localparam int LEN_W   = 4;
    localparam int MAX_LEN = 10;
    localparam int NCH     = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clk_en = 1'b0;
    logic              ser_in = 1'b1;
    logic [NCH-1:0]    ser_out;
    logic              ser_out_valid;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] chan;
    logic [6:0]        ssd_out;

    // Active-low segment codes for digits 0..3.
    logic [6:0] ssd_exp [4] = '{7'h40, 7'h79, 7'h24, 7'h30};

    typedef struct {
        string          tag;
        logic [NCH-1:0] so;
        logic           v;
        logic           d;
        logic           e;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    serial_demux_ctrl #(
        .ADDR_W        (ADDR_W),
        .LEN_W         (LEN_W),
        .MAX_LEN       (MAX_LEN),
        .RESYNC        (4),
        .SSD_ACTIVE_LOW(1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .ser_in       (ser_in),
        .ser_out      (ser_out),
        .ser_out_valid(ser_out_valid),
        .done         (done),
        .err          (err),
        .chan         (chan),
        .ssd_out      (ssd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge. Drives one enabled bit; eso is ser_out during
    // the bit, ev/ed/ee are the flags after the step; gap adds disabled clocks after it.
    task automatic step(input logic b, input logic [NCH-1:0] eso, input logic ev,
                        input logic ed, input logic ee, input int gap, input string tag);
        exp_t           e;
        exp_t           got;
        logic [NCH-1:0] so_pre;
        ser_in = b;
        clk_en = 1'b1;
        e.tag = tag; e.so = eso; e.v = ev; e.d = ed; e.e = ee;
        sb.push_back(e);
        #1 so_pre = ser_out;
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        got = sb.pop_front();
        chk({got.tag, ".ser_out"}, 32'(so_pre), 32'(got.so));
        chk({got.tag, ".valid"}, 32'(ser_out_valid), 32'(got.v));
        chk({got.tag, ".done"}, 32'(done), 32'(got.d));
        chk({got.tag, ".err"}, 32'(err), 32'(got.e));
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
            chk({got.tag, ".hold_valid"}, 32'(ser_out_valid), 32'(got.v));
            chk({got.tag, ".hold_done"}, 32'(done), 32'(got.d));
            chk({got.tag, ".hold_err"}, 32'(err), 32'(got.e));
        end
        @(negedge clk);
    endtask

    // Whole frame; expectations come from the frame fields. For len > MAX_LEN it stops
    // after the length field with err expected high.
    task automatic send_frame(input int a, input int len, input logic [15:0] pay,
                              input logic done_bit, input int gap, input string tag);
        logic [3:0]     av;
        logic [3:0]     lv;
        logic [NCH-1:0] onehot;
        logic           last;
        av = 4'(a);
        lv = 4'(len);
        onehot = NCH'(1) << a;
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, gap, {tag, ".start"});
        for (int i = ADDR_W - 1; i >= 0; i--)
            step(av[i], '0, 1'b0, 1'b0, 1'b0, gap, {tag, ".addr"});
        for (int i = LEN_W - 1; i >= 0; i--) begin
            last = (i == 0);
            step(lv[i], '0, last && len > 0 && len <= MAX_LEN, last && len == 0,
                 last && len > MAX_LEN, gap, {tag, ".len"});
        end
        if (len > MAX_LEN) return;
        for (int k = len - 1; k >= 0; k--) begin
            last = (k == 0);
            step(pay[k], pay[k] ? onehot : '0, !last, last, 1'b0, gap, {tag, ".data"});
        end
        step(done_bit, '0, 1'b0, 1'b0, 1'b0, gap, {tag, ".after_done"});
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst.ser_out", 32'(ser_out), 32'(0));
        chk("rst.valid", 32'(ser_out_valid), 32'(0));
        chk("rst.done", 32'(done), 32'(0));
        chk("rst.err", 32'(err), 32'(0));
        chk("rst.chan", 32'(chan), 32'(0));
        chk("rst.ssd", 32'(ssd_out), 32'(ssd_exp[0]));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        step(1'b1, '0, 1'b0, 1'b0, 1'b0, 0, "idle");

        // Frame to channel 2, payload 101
        send_frame(2, 3, 16'b101, 1'b1, 0, "t1");
        chk("t1.chan", 32'(chan), 32'(2));
        chk("t1.ssd", 32'(ssd_out), 32'(ssd_exp[2]));

        // Zero length to channel 1
        send_frame(1, 0, 16'h0, 1'b1, 0, "t2");
        chk("t2.chan", 32'(chan), 32'(1));
        chk("t2.ssd", 32'(ssd_out), 32'(ssd_exp[1]));

        // Length 12 > MAX_LEN to channel 3, then resync on four consecutive ones
        send_frame(3, 12, 16'h0, 1'b1, 0, "t3");
        step(1'b1, '0, 1'b0, 1'b0, 1'b1, 0, "t3.rs1");
        step(1'b1, '0, 1'b0, 1'b0, 1'b1, 0, "t3.rs2");
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 0, "t3.rs3");
        step(1'b1, '0, 1'b0, 1'b0, 1'b1, 0, "t3.rs4");
        step(1'b1, '0, 1'b0, 1'b0, 1'b1, 0, "t3.rs5");
        step(1'b1, '0, 1'b0, 1'b0, 1'b1, 0, "t3.rs6");
        step(1'b1, '0, 1'b0, 1'b0, 1'b0, 0, "t3.rs7");
        chk("t3.chan", 32'(chan), 32'(3));
        chk("t3.ssd", 32'(ssd_out), 32'(ssd_exp[3]));

        // Same frame as t1 with clk_en high only every 5th clock
        send_frame(2, 3, 16'b101, 1'b1, 4, "t4");
        chk("t4.chan", 32'(chan), 32'(2));

        // Reset in the middle of a 7-bit payload to channel 1
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 0, "t5.start");
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 0, "t5.addr");
        step(1'b1, '0, 1'b0, 1'b0, 1'b0, 0, "t5.addr");
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 0, "t5.len");
        step(1'b1, '0, 1'b0, 1'b0, 1'b0, 0, "t5.len");
        step(1'b1, '0, 1'b0, 1'b0, 1'b0, 0, "t5.len");
        step(1'b1, '0, 1'b1, 1'b0, 1'b0, 0, "t5.len");
        step(1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 0, "t5.data");
        step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 0, "t5.data");
        step(1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 0, "t5.data");
        chk("t5.pre_chan", 32'(chan), 32'(1));
        ser_in = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("t5.rst_ser_out", 32'(ser_out), 32'(0));
        chk("t5.rst_valid", 32'(ser_out_valid), 32'(0));
        chk("t5.rst_done", 32'(done), 32'(0));
        chk("t5.rst_chan", 32'(chan), 32'(0));
        chk("t5.rst_ssd", 32'(ssd_out), 32'(ssd_exp[0]));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_frame(3, 2, 16'b01, 1'b1, 0, "t5b");
        chk("t5b.chan", 32'(chan), 32'(3));

        // Back-to-back frames; a start bit on the done step must be ignored
        send_frame(0, 1, 16'b1, 1'b1, 0, "t6a");
        send_frame(3, 2, 16'b10, 1'b0, 0, "t6b");
        send_frame(1, 1, 16'b1, 1'b1, 0, "t6c");
        chk("t6.chan", 32'(chan), 32'(1));
        chk("t6.ssd", 32'(ssd_out), 32'(ssd_exp[1]));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
